// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one bit per clock, LSB first
// Optional overflow flag: define SERIAL_ADDER_OVF_EN to compute V; otherwise V is tied to 0.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         Sub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   res;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           sum_bit;
  logic           carry_next;

  // Single full-adder slice working on the operand LSBs and the carry flop
  always_comb begin
    sum_bit    = a_reg[0] ^ b_reg[0] ^ carry;
    carry_next = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: W RUN cycles, one DONE cycle, back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef SERIAL_ADDER_OVF_EN
  logic v_int;

  // Overflow capture: carry into the MSB xor carry out of the MSB
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_int <= 1'b0;
      V     <= 1'b0;
    end else begin
      if (state == RUN && cnt == LAST) v_int <= carry ^ carry_next;
      if (state == DONE) V <= v_int;
    end
  end
`else
  assign V = 1'b0;
`endif

  // Datapath: operand latch, serial shift/accumulate, result publish
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg <= '0;
      b_reg <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, with Cin acting as borrow-in
            a_reg <= A;
            b_reg <= B ^ {W{Sub}};
            carry <= Cin ^ Sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= carry_next;
          res   <= {sum_bit, res[W-1:1]};
          a_reg <= {1'b0, a_reg[W-1:1]};
          b_reg <= {1'b0, b_reg[W-1:1]};
          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          S    <= res;
          Cout <= carry;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder
module tb_serial_adder;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         v;
  } exp_t;

  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  serial_adder #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .S(S), .Cout(Cout), .V(V), .busy(busy), .done(done)
  );

  function automatic exp_t model(input logic sub, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t e;
    logic [W:0] u;
    logic signed [W:0] sa;
    logic signed [W:0] sb;
    logic signed [W:0] sc;
    logic signed [W:0] sr;
    sa = $signed({a[W-1], a});
    sb = $signed({b[W-1], b});
    sc = $signed({{W{1'b0}}, cin});
    if (!sub) begin
      u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.s    = u[W-1:0];
      e.cout = u[W];
      sr     = sa + sb + sc;
    end else begin
      u      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      e.s    = u[W-1:0];
      e.cout = ~u[W];
      sr     = sa - sb - sc;
    end
`ifdef SERIAL_ADDER_OVF_EN
    e.v = sr[W] ^ sr[W-1];
`else
    e.v = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done S=%h Cout=%b V=%b", S, Cout, V);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (S !== e.s) begin
          failures++;
          $display("FAIL result_S got=%h exp=%h", S, e.s);
        end
        checks++;
        if (Cout !== e.cout) begin
          failures++;
          $display("FAIL result_Cout got=%b exp=%b", Cout, e.cout);
        end
        checks++;
        if (V !== e.v) begin
          failures++;
          $display("FAIL result_V got=%b exp=%b", V, e.v);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge
  task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit expect_result);
    Sub = sub; A = a; B = b; Cin = cin; start = 1'b1;
    if (expect_result) sb_q.push_back(model(sub, a, b, cin));
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Edges counted from the start edge until done is seen; -1 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end while (done !== 1'b1 && lat < 40);
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b1; Sub = 1'b0; A = '1; B = '1; Cin = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (S !== '0)      begin failures++; $display("FAIL reset_S got=%h exp=00", S); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL reset_Cout got=%b exp=0", Cout); end
    checks++; if (V !== 1'b0)    begin failures++; $display("FAIL reset_V got=%b exp=0", V); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    RST = 1'b0; start = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_add;
    logic [W-1:0] ta [3] = '{8'h3C, 8'hFF, 8'hFF};
    logic [W-1:0] tb [3] = '{8'h05, 8'h01, 8'h01};
    logic         tc [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, ta[i], tb[i], tc[i], 1'b1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy_run got=%b exp=1", busy); end
      wait_done(lat);
      checks++; if (lat != W + 1) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", lat, W + 1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_at_done got=%b exp=0", busy); end
      @(negedge CLK);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_width got=%b exp=0", done); end
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] ta [2] = '{8'h05, 8'h07};
    logic [W-1:0] tb [2] = '{8'h07, 8'h05};
    logic         tc [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, ta[i], tb[i], tc[i], 1'b1);
      wait_done(lat);
      checks++; if (lat != W + 1) begin failures++; $display("FAIL sub_latency got=%0d exp=%0d", lat, W + 1); end
      @(negedge CLK);
    end
  endtask

  task automatic test_overflow;
    logic         ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ta [4] = '{8'h7F, 8'h80, 8'h80, 8'h7F};
    logic [W-1:0] tb [4] = '{8'h01, 8'h01, 8'h80, 8'hFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ts[i], ta[i], tb[i], 1'b0, 1'b1);
      wait_done(lat);
      checks++; if (lat != W + 1) begin failures++; $display("FAIL ovf_latency got=%0d exp=%0d", lat, W + 1); end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    int lat;
    issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (S !== '0)      begin failures++; $display("FAIL abort_S got=%h exp=00", S); end
    RST = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge CLK);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if (lat != W + 1) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=%0d", lat, W + 1); end
    @(negedge CLK);
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int nbusy = 0;
    issue(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    start = 1'b1; A = 8'hAA;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
    end
    checks++; if (ndone != 1)     begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (nbusy != W - 3) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", nbusy, W - 3); end
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    issue(1'b0, 8'h12, 8'h34, 1'b1, 1'b1);
    wait_done(lat1);
    issue(1'b1, 8'h34, 8'h12, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accepted got=%b exp=1", busy); end
    wait_done(lat2);
    checks++; if (lat1 != W + 1) begin failures++; $display("FAIL b2b_latency1 got=%0d exp=%0d", lat1, W + 1); end
    checks++; if (lat2 != W + 1) begin failures++; $display("FAIL b2b_latency2 got=%0d exp=%0d", lat2, W + 1); end
    @(negedge CLK);
  endtask

  task automatic test_random;
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_done(lat);
      checks++; if (lat != W + 1) begin failures++; $display("FAIL rand_latency got=%0d exp=%0d", lat, W + 1); end
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_overflow;
    test_reset_abort;
    test_ignore_start;
    test_back_to_back;
    test_random;
    repeat (4) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter W, default 8, meaning operand/result width in bits (legal range W >= 2).
REQ-002 Port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Port RST  input  1  reset; synchronous and active-high.
REQ-004 Port start  input  1  request to begin an operation; sampled only while idle.
REQ-005 Port Sub  input  1  mode select: 0 = add, 1 = subtract; sampled with start.
REQ-006 Port A  input  W  first operand; sampled with start.
REQ-007 Port B  input  W  second operand; sampled with start.
REQ-008 Port Cin  input  1  carry-in when adding, borrow-in when subtracting; sampled with start.
REQ-009 Port S  output  W  registered result word.
REQ-010 Port Cout  output  1  registered final carry; when subtracting, 1 = no borrow.
REQ-011 Port V  output  1  registered two's-complement overflow flag.
REQ-012 Port busy  output  1  high while an operation is in progress.
REQ-013 Port done  output  1  one-cycle pulse marking S/Cout/V valid.

Function
REQ-014 The block SHALL use one 1-bit full-adder slice plus a carry flip-flop, processing one bit per cycle, LSB first.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: start=1 at an edge SHALL latch A, B xor {W{Sub}}, and initial carry = Cin xor Sub; clear the bit counter; go to RUN.
REQ-017 RUN: each cycle SHALL compute sum bit = a0 ^ b0 ^ c, store the new carry, shift the sum bit into an internal result register at the MSB, shift both operand registers right, and increment the counter.
REQ-018 RUN SHALL go to DONE on the cycle that processes bit W-1, i.e. after exactly W RUN cycles.
REQ-019 DONE: S, Cout and V SHALL be loaded from the internal result, done SHALL be 1 for exactly this cycle, and the FSM SHALL return to IDLE.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge W+1; back-to-back starts SHALL allow one operation per W+2 cycles.
REQ-021 Add SHALL compute {Cout,S} = A + B + Cin, modulo 2^(W+1).
REQ-022 Subtract SHALL compute S = A - B - Cin mod 2^W, with Cout = 0 if and only if a borrow occurred.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-024 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-025 S, Cout and V SHALL hold their last result unchanged until the next DONE; input changes during RUN SHALL NOT affect the result.

Reset
REQ-026 RST=1 at an edge SHALL force IDLE and set S=0, Cout=0, V=0, busy=0, done=0, and clear the counter, carry and internal registers.
REQ-027 RST SHALL take priority over start.
REQ-028 A reset mid-operation SHALL abort that operation without producing a done pulse.

Configuration
REQ-029 Macro SERIAL_ADDER_OVF_EN defined: V SHALL equal (carry into bit W-1) xor (carry out of bit W-1), loaded at DONE.
REQ-030 Macro SERIAL_ADDER_OVF_EN undefined: the V port SHALL remain present, tied to 0, with no overflow logic synthesised.

Verification
REQ-031 W=8, Sub=0, A=0x3C, B=0x05, Cin=0 -> S=0x41, Cout=0, V=0, done high exactly 9 cycles after the start edge, then busy=0.
REQ-032 W=8, Sub=0, A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, V=0; repeat with Cin=1 -> S=0x01, Cout=1.
REQ-033 W=8, Sub=1, A=0x05, B=0x07, Cin=0 -> S=0xFE, Cout=0, V=0; Sub=1, A=0x07, B=0x05, Cin=1 -> S=0x01, Cout=1.
REQ-034 W=8, Sub=0, A=0x7F, B=0x01 -> S=0x80, V=1 with SERIAL_ADDER_OVF_EN defined and V=0 without it; Sub=1, A=0x80, B=0x01 -> S=0x7F, V=1 when enabled.
REQ-035 Start A=0x10, B=0x20, assert RST in the 4th RUN cycle -> next cycle busy=0, S=0, no done pulse; a fresh start then completes normally.
REQ-036 Start with A=0x01, B=0x01, then pulse start with A=0xAA during RUN -> single done pulse, S=0x02, and no second operation begins.
